// File: rtl/uart_pkg.sv
// Shared UART definitions: receive-state encoding and default bit timing.
// Optional macro UART_RX_PARITY_EN adds the PARITY receive state.
package uart_pkg;

    // 100 MHz clock / 115200 baud
    localparam int unsigned UART_CLKS_PER_BIT = 868;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_STOP   = 3'd3,
        RX_PARITY = 3'd4
    } rx_state_t;
`else
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;
`endif

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Synchronous show-ahead FIFO; rd_data is the head entry, forced to 0 when empty.
// Pointers carry one extra wrap bit so full/empty come from an MSB compare.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_pop;
    logic             do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // a pop in the same cycle frees the slot, so a push into a full FIFO is accepted
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // pointer advance and storage write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1) feeding a show-ahead receive FIFO, with sticky
// overrun/frame error flags. Define UART_RX_PARITY_EN for 8E1 framing,
// which adds a PARITY state and a sticky parity_err output.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned DEPTH        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       rd_en,
    input  logic       clr_err,
    output logic [7:0] rd_data,
    output logic       rx_empty,
    output logic       rx_full,
    output logic       overrun,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       frame_err
);

    localparam int unsigned   CW        = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);

    logic          rx_s1;
    logic          rx_s2;
    logic          rx_prev;
    logic          fall;
    logic          tick;
    rx_state_t     state;
    rx_state_t     state_nxt;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          push;
    logic          frame_set;
    logic          overrun_set;
`ifdef UART_RX_PARITY_EN
    logic          par_ok;
    logic          par_set;
`endif

    assign fall        = rx_prev && !rx_s2;
    assign tick        = (cnt == '0);
    assign overrun_set = push && rx_full && !rd_en;

    // two-flop synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rxd;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // receive state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= RX_IDLE;
        else        state <= state_nxt;
    end

    // next-state decode and per-frame push/error strobes
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_set   = 1'b0;
`endif
        case (state)
            RX_IDLE:  if (fall) state_nxt = RX_START;
            RX_START: if (tick) state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA: begin
                if (tick && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = RX_PARITY;
`else
                    state_nxt = RX_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (tick) begin
                    state_nxt = RX_STOP;
                    par_set   = ^{shreg, rx_s2};
                end
            end
`endif
            RX_STOP: begin
                if (tick) begin
                    state_nxt = RX_IDLE;
`ifdef UART_RX_PARITY_EN
                    push      = rx_s2 && par_ok;
`else
                    push      = rx_s2;
`endif
                    frame_set = !rx_s2;
                end
            end
            default:  state_nxt = RX_IDLE;
        endcase
    end

    // bit timer, bit index and LSB-first shift register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
`ifdef UART_RX_PARITY_EN
            par_ok  <= 1'b1;
`endif
        end else if (state == RX_IDLE) begin
            bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
            par_ok  <= 1'b1;
`endif
            if (fall) cnt <= HALF_LOAD;
        end else if (tick) begin
            cnt <= BIT_LOAD;
            if (state == RX_START) bit_idx <= '0;
            if (state == RX_DATA) begin
                shreg   <= {rx_s2, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
`ifdef UART_RX_PARITY_EN
            if (state == RX_PARITY) par_ok <= !par_set;
`endif
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    // sticky error flags: a same-cycle set wins over clr_err
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            if (overrun_set)  overrun <= 1'b1;
            else if (clr_err) overrun <= 1'b0;
            if (frame_set)    frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            if (par_set)      parity_err <= 1'b1;
            else if (clr_err) parity_err <= 1'b0;
`endif
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (shreg),
        .pop       (rd_en),
        .rd_data   (rd_data),
        .full      (rx_full),
        .empty     (rx_empty)
    );

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clocks per UART bit (100 MHz / 115200 baud), minimum 4.
REQ-002 SHALL have parameter DEPTH, default 16, FIFO entries, power of two, minimum 2.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous active-low reset; low clears all state.
REQ-005 SHALL have port rxd  input  1  asynchronous serial line, idle high, 8N1 (8E1 under macro).
REQ-006 SHALL have port rd_en  input  1  pop request from core load path.
REQ-007 SHALL have port clr_err  input  1  clears sticky error flags.
REQ-008 SHALL have port rd_data  output  8  FIFO head byte (show-ahead); 0 when empty.
REQ-009 SHALL have port rx_empty  output  1  FIFO holds no bytes.
REQ-010 SHALL have port rx_full  output  1  FIFO holds DEPTH bytes.
REQ-011 SHALL have port overrun  output  1  sticky; a received byte was dropped.
REQ-012 SHALL have port frame_err  output  1  sticky; a stop bit sampled low.

Function
REQ-013 SHALL pass rxd through a 2-flop synchronizer before any use; both flops reset to 1.
REQ-014 SHALL implement states IDLE, START, DATA, STOP (PARITY under macro) with a down-counter of width clog2(CLKS_PER_BIT)+1.
REQ-015 IDLE: a high-to-low transition of synced rxd SHALL enter START with counter loaded to CLKS_PER_BIT/2-1; a line held low SHALL not retrigger.
REQ-016 START: at counter 0, sample low -> DATA (counter CLKS_PER_BIT-1, bit index 0); sample high -> IDLE, nothing recorded (glitch reject).
REQ-017 DATA: SHALL sample once per CLKS_PER_BIT at counter 0, LSB first; after bit 7 -> STOP (or PARITY).
REQ-018 STOP: sample high SHALL push the byte; sample low SHALL discard it, set frame_err; both -> IDLE.
REQ-019 Pushed byte SHALL be visible on rd_data with rx_empty=0 on the cycle after the stop-sample cycle.
REQ-020 rd_en with rx_empty=1 SHALL be ignored; rd_en with rx_empty=0 SHALL advance the head at the clock edge.
REQ-021 Push with rx_full=1 and no same-cycle rd_en SHALL drop the byte, set overrun, leave FIFO unchanged.
REQ-022 Push with rx_full=1 and same-cycle rd_en SHALL pop and push; occupancy stays DEPTH, no overrun.
REQ-023 Pointers SHALL be clog2(DEPTH)+1 bits, wrap modulo 2*DEPTH; full/empty from MSB compare.
REQ-024 clr_err SHALL clear overrun and frame_err; a same-cycle set SHALL win over clear.

Reset
REQ-025 reset low SHALL asynchronously force IDLE, counters/pointers 0, rd_data 0, rx_empty 1, rx_full 0, overrun 0, frame_err 0.
REQ-026 reset asserted mid-frame SHALL discard the partial byte; after release the receiver SHALL wait for a new falling edge.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined SHALL add state PARITY after bit 7 checking even parity, and output port parity_err (sticky, cleared by clr_err); mismatch discards the byte and sets parity_err.
REQ-028 Without UART_RX_PARITY_EN SHALL have no PARITY state and no parity_err port; frame is 8N1.

Structure
REQ-029 Package uart_pkg SHALL hold the rx state encoding and default CLKS_PER_BIT constant, shared with the transmit side.
REQ-030 FIFO SHALL be sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty, show-ahead).

Verification (CLKS_PER_BIT=16, DEPTH=4)
REQ-031 Send 0xA5 8N1 -> rd_data=0xA5, rx_empty=0 one cycle after stop sample; rd_en one cycle -> rx_empty=1, rd_data=0.
REQ-032 Low pulse of 5 clocks on idle rxd -> no push, state back to IDLE, no error flags.
REQ-033 Send 0x3C with stop bit low -> frame_err=1, rx_empty stays 1; clr_err -> frame_err=0.
REQ-034 Send 0x01..0x05 without reads -> rx_full=1 after 4th, overrun=1 after 5th, reads return 0x01..0x04.
REQ-035 FIFO full, 5th stop sample coincides with rd_en -> overrun=0, reads return 0x02..0x05.
REQ-036 Assert reset during bit 4 of 0xFF -> all outputs at reset values; following 0x55 received intact (with UART_RX_PARITY_EN: 0x55 wrong parity -> parity_err=1, no push).
